// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg -- two-entry skid buffer between pipeline stages.
//
// Holds up to two entries: a main register that drives out_data, and a
// skid register that catches one extra entry while downstream is busy.
// in_ready and out_valid come straight from the state register, so there
// is no combinational path from out_ready, stall or flush back to in_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (clears state and storage)
//   flush      discard all held entries; wins over push, pop and stall
//   stall      downstream hold, blocks pop
//   in_valid   upstream offers in_data
//   in_data    upstream payload [DATA_W-1:0]
//   in_ready   block accepts in_data this cycle
//   out_valid  out_data is valid
//   out_data   head payload [DATA_W-1:0] (main register, also when invalid)
//   out_ready  downstream accepts out_data
//   occupancy  entries held, 0..2
module pipe_skid_reg #(
    parameter int DATA_W     = 64,
    parameter bit FLUSH_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy
);

    // Encoding matches the entry count so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_p0;
    state_t            state_nxt;
    logic [DATA_W-1:0] main_p0;
    logic [DATA_W-1:0] main_nxt;
    logic [DATA_W-1:0] skid_p0;
    logic [DATA_W-1:0] skid_nxt;
    logic              push;
    logic              pop;

    assign in_ready  = (state_p0 != FULL);
    assign out_valid = (state_p0 != EMPTY);
    assign out_data  = main_p0;
    assign occupancy = state_p0;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready & ~stall;

    always_comb begin
        state_nxt = state_p0;
        main_nxt  = main_p0;
        skid_nxt  = skid_p0;
        if (flush) begin
            // Flush discards everything, including any entry offered this cycle.
            state_nxt = EMPTY;
            if (FLUSH_ZERO) begin
                main_nxt = '0;
                skid_nxt = '0;
            end
        end else begin
            unique case (state_p0)
                EMPTY: begin
                    if (push) begin
                        main_nxt  = in_data;
                        state_nxt = HALF;
                    end
                end
                HALF: begin
                    if (push && pop) begin
                        main_nxt = in_data;
                    end else if (push) begin
                        skid_nxt  = in_data;
                        state_nxt = FULL;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        main_nxt  = skid_p0;
                        state_nxt = HALF;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // ---- stage p0: state and storage registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0 <= EMPTY;
            main_p0  <= '0;
            skid_p0  <= '0;
        end else begin
            state_p0 <= state_nxt;
            main_p0  <= main_nxt;
            skid_p0  <= skid_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

    localparam int DATA_W = 64;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              stall;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [1:0]        occupancy;

    pipe_skid_reg #(
        .DATA_W    (DATA_W),
        .FLUSH_ZERO(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .stall    (stall),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_popped = 0;
    logic [DATA_W-1:0] sb_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Called at a falling edge with inputs already driven. Models the
    // coming rising edge against the scoreboard, then checks the result.
    task automatic tick(input string tag);
        logic do_pop;
        logic do_push;
        logic [DATA_W-1:0] exp_head;
        do_pop  = (sb_q.size() != 0) && out_ready && !stall && !flush;
        do_push = in_valid && (sb_q.size() < 2) && !flush;
        if (do_pop) begin
            exp_head = sb_q.pop_front();
            check({tag, ":pop_data"}, out_data, exp_head);
            n_popped++;
        end
        if (do_push) sb_q.push_back(in_data);
        if (flush) sb_q.delete();
        @(posedge clk);
        #1;
        check({tag, ":occupancy"}, 64'(occupancy), 64'(sb_q.size()));
        check({tag, ":out_valid"}, 64'(out_valid), 64'(sb_q.size() != 0));
        check({tag, ":in_ready"}, 64'(in_ready), 64'(sb_q.size() < 2));
        if (sb_q.size() != 0) check({tag, ":head"}, out_data, sb_q[0]);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic ordy,
                         input logic stl, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        stall     = stl;
        flush     = fl;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #2;
        check("reset:occupancy", 64'(occupancy), 64'd0);
        check("reset:out_valid", 64'(out_valid), 64'd0);
        check("reset:in_ready", 64'(in_ready), 64'd1);
        check("reset:out_data", out_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single entry: push 0xA, appears after one edge, popped the next.
        drive(1'b1, 64'hA, 1'b1, 1'b0, 1'b0);
        tick("single_push");
        check("single_push:data", out_data, 64'hA);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick("single_pop");

        // Fill to FULL with downstream blocked, then drain in order.
        drive(1'b1, 64'h1, 1'b0, 1'b0, 1'b0);
        tick("fill1");
        drive(1'b1, 64'h2, 1'b0, 1'b0, 1'b0);
        tick("fill2");
        check("fill2:in_ready_low", 64'(in_ready), 64'd0);
        drive(1'b1, 64'h3, 1'b0, 1'b0, 1'b0);
        tick("full_reject");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            tick("drain");
        end
        check("drain:popped", 64'(n_popped), 64'd3);

        // FULL held under stall for three cycles, then drains.
        drive(1'b1, 64'h11, 1'b0, 1'b0, 1'b0);
        tick("stall_fill1");
        drive(1'b1, 64'h22, 1'b0, 1'b0, 1'b0);
        tick("stall_fill2");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
            tick("stalled");
            check("stalled:held_data", out_data, 64'h11);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            tick("stall_drain");
        end

        // Flush from FULL while a new entry is offered.
        drive(1'b1, 64'h33, 1'b0, 1'b0, 1'b0);
        tick("flush_fill1");
        drive(1'b1, 64'h44, 1'b0, 1'b0, 1'b0);
        tick("flush_fill2");
        drive(1'b1, 64'h5, 1'b1, 1'b1, 1'b1);
        tick("flush");
        check("flush:main_zero", out_data, 64'd0);
        check("flush:skid_zero", dut.skid_p0, 64'd0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            tick("post_flush_idle");
        end
        drive(1'b1, 64'h66, 1'b1, 1'b0, 1'b0);
        tick("post_flush_push");
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick("post_flush_pop");

        // Streaming 1..100 with push and pop every cycle.
        n_popped = 0;
        for (int i = 1; i <= 100; i++) begin
            drive(1'b1, 64'(i), 1'b1, 1'b0, 1'b0);
            tick("stream");
            check("stream:occ_one", 64'(occupancy), 64'd1);
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick("stream_tail");
        check("stream:popped", 64'(n_popped), 64'd100);

        // Asynchronous reset between edges while holding one entry.
        drive(1'b1, 64'h77, 1'b0, 1'b0, 1'b0);
        tick("areset_fill");
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("areset:out_valid", 64'(out_valid), 64'd0);
        check("areset:occupancy", 64'(occupancy), 64'd0);
        check("areset:in_ready", 64'(in_ready), 64'd1);
        check("areset:out_data", out_data, 64'd0);
        #1 rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        drive(1'b1, 64'h88, 1'b0, 1'b0, 1'b0);
        tick("areset_push");
        check("areset_push:data", out_data, 64'h88);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick("areset_pop");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning the payload width in bits (e.g. {pc, instr} at 32+32).
REQ-002 The block SHALL have parameter FLUSH_ZERO, default 1, meaning storage registers are cleared to 0 on flush when 1 and left unchanged when 0.
REQ-003 The block SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port flush  input  1  discard all held entries.
REQ-006 The block SHALL have port stall  input  1  downstream hold; blocks pop.
REQ-007 The block SHALL have port in_valid  input  1  upstream offers in_data.
REQ-008 The block SHALL have port in_data  input  DATA_W  upstream payload.
REQ-009 The block SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-010 The block SHALL have port out_valid  output  1  out_data is valid.
REQ-011 The block SHALL have port out_data  output  DATA_W  head payload.
REQ-012 The block SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-013 The block SHALL have port occupancy  output  2  entries held (0..2).

Function
REQ-014 The block SHALL hold two entries: main register (drives out_data) and skid register.
REQ-015 The block SHALL use a state machine with states EMPTY (0 entries), HALF (1 entry), FULL (2 entries); occupancy SHALL equal 0/1/2 respectively.
REQ-016 The block SHALL define push = in_valid & in_ready, and pop = out_valid & out_ready & ~stall.
REQ-017 The block SHALL decode in_ready = (state != FULL) and out_valid = (state != EMPTY) from the state register only, with no combinational path from out_ready, stall or flush to in_ready.
REQ-018 In EMPTY, push SHALL load main with in_data and go to HALF; otherwise the block SHALL remain in EMPTY.
REQ-019 In HALF, the block SHALL behave as follows:
  - push & pop: load main with in_data, stay HALF;
  - push only: load skid with in_data, go FULL;
  - pop only: go EMPTY;
  - neither: hold.
REQ-020 In FULL, pop SHALL move skid into main and go to HALF; otherwise the block SHALL hold.
REQ-021 Ordering SHALL be strict FIFO; no entry SHALL be duplicated or dropped except by flush.
REQ-022 Latency SHALL be one cycle: data pushed at edge N SHALL appear on out_data with out_valid=1 after edge N when the block was EMPTY.
REQ-023 Sustained push and pop every cycle SHALL give throughput of one entry per cycle with state HALF.
REQ-024 flush SHALL have priority over push, pop and stall: next state EMPTY, and any in_data offered that cycle SHALL be discarded.
REQ-025 With FLUSH_ZERO=1, flush SHALL clear main and skid to 0; with FLUSH_ZERO=0 they SHALL keep their values.
REQ-026 stall=1 with flush=0 SHALL block pop; push SHALL still be allowed while in_ready=1.
REQ-027 When out_valid=0, out_data SHALL show the main register contents and SHALL be ignored downstream.

Reset
REQ-028 rst=1 SHALL immediately, without a clock edge, force state EMPTY, main=0, skid=0, occupancy=0, out_valid=0 and in_ready=1.
REQ-029 While rst=1, no push or pop SHALL take effect.
REQ-030 Reset asserted mid-operation SHALL discard all held entries.
REQ-031 After rst deasserts, the first edge SHALL accept a push.

Verification
REQ-032 The bench SHALL cover: reset, then push 0xA at edge 1 with out_ready=1 -> out_valid=1, out_data=0xA, occupancy=1 after edge 1; popped at edge 2.
REQ-033 The bench SHALL cover: out_ready=0, push 0x1 then 0x2 -> occupancy=2, in_ready=0; then out_ready=1 -> out_data 0x1, then 0x2, then out_valid=0.
REQ-034 The bench SHALL cover: FULL with stall=1 and out_ready=1 for 3 cycles -> state, occupancy=2 and out_data held; stall=0 -> drains in order.
REQ-035 The bench SHALL cover: FULL, flush=1 with in_valid=1 and in_data=0x5 -> next cycle occupancy=0, out_valid=0, main=skid=0 (FLUSH_ZERO=1), and 0x5 never emerges.
REQ-036 The bench SHALL cover: in_valid=out_ready=1 every cycle with data 1..100 -> out_data sequence 1..100 in order, no gaps after first output, occupancy constant at 1.
REQ-037 The bench SHALL cover: rst pulsed asynchronously between edges while HALF -> out_valid=0 and occupancy=0 immediately; the next push after release is accepted.
